// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle one-bit-per-clock shifter (SLL/SRL/SRA/ROL) with valid/ready handshake
// Full-width result plus a PC-width truncation and a flag for dropped set bits.
module seq_shift_unit #(
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 15,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [OUT_W-1:0]   out_trunc,
    output logic               out_lost
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_acc;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_lost;

    logic [DATA_W-1:0]  w_step;
    logic [CNT_W-1:0]   w_count_init;
    logic               w_lost;

    // Oversized amounts clamp to DATA_W so every mode still shifts a full word.
    assign w_count_init = (int'(in_shamt) >= DATA_W) ? CNT_W'(DATA_W) : CNT_W'(in_shamt);

    always_comb begin
        w_step = r_acc;
        case (r_mode)
            2'b00:   w_step = {r_acc[DATA_W-2:0], 1'b0};
            2'b01:   w_step = {1'b0, r_acc[DATA_W-1:1]};
            2'b10:   w_step = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
            default: w_step = {r_acc[DATA_W-2:0], r_acc[DATA_W-1]};
        endcase
    end

    generate
        if (OUT_W < DATA_W) begin : g_lost
            assign w_lost = |r_acc[DATA_W-1:OUT_W];
        end else begin : g_no_lost
            assign w_lost = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_mode      <= 2'b00;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lost  <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc   <= in_data;
                        r_mode  <= in_mode;
                        r_count <= w_count_init;
                        r_state <= (w_count_init == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc   <= w_step;
                    r_count <= r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc;
                        r_out_lost  <= w_lost;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_trunc = r_out_data[OUT_W-1:0];
    assign out_lost  = r_out_lost;
endmodule
